arm_mc_controller: RTL and testbench

Multicycle control unit for the ARM datapath. Sequences fetch, decode, execute, memory access and writeback across several cycles using a Moore FSM. Waits on a req/ack memory handshake. Owns the NZCV flag register, which drives `storedCarry`, and performs ARM condition checking. It supplies every control input the datapath consumes.

---
 rtl/arm_ctrl_pkg.sv | 78 +++++++
 rtl/cond_unit.sv | 30 +++
 rtl/arm_mc_controller.sv | 174 +++++++++++++++++
 tb/tb_arm_mc_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the ARM multicycle control unit.
// Contents: FSM state enum, ALU opcode / condition / shifter encodings,
// and the ARM condition-code evaluation helper.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_I, S_EXEC_R, S_EXEC_RS, S_ALU_WB,
    S_MEM_ADR, S_MEM_RD, S_MEM_WR, S_MEM_WB, S_BRANCH
  } state_e;

  // ALU opcodes (ARM data-processing opcode field)
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_RSB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ADC = 4'b0101;
  localparam logic [3:0] ALU_SBC = 4'b0110;
  localparam logic [3:0] ALU_RSC = 4'b0111;
  localparam logic [3:0] ALU_TST = 4'b1000;
  localparam logic [3:0] ALU_TEQ = 4'b1001;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_CMN = 4'b1011;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_BIC = 4'b1110;
  localparam logic [3:0] ALU_MVN = 4'b1111;

  // Condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Shifter operations
  localparam logic [2:0] SH_LSL = 3'b000;
  localparam logic [2:0] SH_LSR = 3'b001;
  localparam logic [2:0] SH_ASR = 3'b010;
  localparam logic [2:0] SH_ROR = 3'b011;
  localparam logic [2:0] SH_RRX = 3'b100;

  // Evaluate an ARM condition field against NZCV ({N,Z,C,V}).
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = !z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = !c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = !n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = !v;
      COND_HI: cond_check = c && !z;
      COND_LS: cond_check = !c || z;
      COND_GE: cond_check = (n == v);
      COND_LT: cond_check = (n != v);
      COND_GT: cond_check = !z && (n == v);
      COND_LE: cond_check = z || (n != v);
      COND_AL: cond_check = 1'b1;
      default: cond_check = 1'b0;  // NV: never
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register plus condition evaluation.
// Ports: clk/rst_n (async active-low), flag_we_i loads alu_flags_i into NZCV,
// cond_i is the instruction condition field, cond_ex_o says it passes,
// stored_carry_o is the C flag.
module cond_unit
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we_i,
  input  logic [3:0] alu_flags_i,
  input  logic [3:0] cond_i,
  output logic       cond_ex_o,
  output logic       stored_carry_o
);

  logic [3:0] nzcv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= 4'b0000;
    end else if (flag_we_i) begin
      nzcv_q <= alu_flags_i;
    end
  end

  assign cond_ex_o      = cond_check(cond_i, nzcv_q);
  assign stored_carry_o = nzcv_q[1];

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback with a req/ack memory handshake, plus the NZCV register.
// Inputs: clk, reset (async active-low), Instr, ALUFlags, mem_ack.
// Outputs: memory handshake (mem_req, MemWrite, AdrSrc), PC/IR control,
// register file and datapath mux selects, ALU/shifter controls,
// storedCarry (flag C) and illegal_op (pulse on an 11 op field).
module arm_mc_controller
  import arm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        linkSelect,
  output logic [3:0]  ALUControl,
  output logic [2:0]  shiftOp,
  output logic        registerShift,
  output logic        storedCarry,
  output logic        illegal_op
);

  state_e state_q, state_d;

  logic [1:0] op;
  logic [3:0] opcode;
  logic       i_bit, s_bit, rd_is_pc, rrx, dp_wr, cond_ex, flag_we;
  logic [2:0] dp_shift;

  assign op       = Instr[27:26];
  assign i_bit    = Instr[25];
  assign opcode   = Instr[24:21];
  assign s_bit    = Instr[20];
  assign rd_is_pc = (Instr[15:12] == 4'hF);
  // ROR #0 on a register operand encodes RRX
  assign rrx      = (Instr[6:5] == 2'b11) && (Instr[11:7] == 5'd0) && !Instr[4] && !i_bit;
  assign dp_shift = i_bit ? SH_ROR : (rrx ? SH_RRX : {1'b0, Instr[6:5]});
  // TST/TEQ/CMP/CMN only set flags
  assign dp_wr    = (opcode[3:2] != 2'b10);

  // Flags load at the end of the final execute cycle (EXEC_RS is never last)
  assign flag_we  = ((state_q == S_EXEC_I) || (state_q == S_EXEC_R)) &&
                    (s_bit || (opcode[3:2] == 2'b10));

  wire unused_instr_bits = ^{Instr[22], Instr[19:16], Instr[3:0]};

  cond_unit u_cond (
    .clk           (clk),
    .rst_n         (reset),
    .flag_we_i     (flag_we),
    .alu_flags_i   (ALUFlags),
    .cond_i        (Instr[31:28]),
    .cond_ex_o     (cond_ex),
    .stored_carry_o(storedCarry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (!cond_ex) begin
          state_d = S_FETCH;
        end else begin
          case (op)
            2'b00:   state_d = i_bit ? S_EXEC_I : (Instr[4] ? S_EXEC_RS : S_EXEC_R);
            2'b01:   state_d = S_MEM_ADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC_RS: state_d = S_EXEC_R;
      S_EXEC_I,
      S_EXEC_R:  state_d = S_ALU_WB;
      S_MEM_ADR: state_d = s_bit ? S_MEM_RD : S_MEM_WR;  // bit 20 is L here
      S_MEM_RD:  if (mem_ack) state_d = S_MEM_WB;
      S_MEM_WR:  if (mem_ack) state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset is held so that
  // mem_req only rises once reset is released.
  always_comb begin
    mem_req       = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCSrc         = 1'b0;
    RegWrite      = 1'b0;
    RegSrc        = 2'b00;
    ImmSrc        = 2'b00;
    ALUSrc        = 1'b0;
    MemtoReg      = 1'b0;
    linkSelect    = 1'b0;
    ALUControl    = 4'b0000;
    shiftOp       = 3'b000;
    registerShift = 1'b0;
    illegal_op    = 1'b0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          IRWrite = mem_ack;
          PCWrite = mem_ack;
        end
        S_DECODE: illegal_op = cond_ex && (op == 2'b11);
        S_EXEC_I, S_EXEC_R, S_EXEC_RS: begin
          ALUControl    = opcode;
          shiftOp       = dp_shift;
          ALUSrc        = i_bit;
          // EXEC_R after EXEC_RS keeps the Rs shift amount selected
          registerShift = (state_q == S_EXEC_RS) || ((state_q == S_EXEC_R) && Instr[4]);
        end
        S_ALU_WB: begin
          RegWrite = dp_wr;
          PCWrite  = dp_wr && rd_is_pc;
          PCSrc    = dp_wr && rd_is_pc;
        end
        S_MEM_ADR: begin
          ImmSrc     = 2'b01;
          ALUSrc     = 1'b1;
          ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          RegSrc   = 2'b10;
        end
        S_MEM_WB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          PCWrite  = rd_is_pc;
          PCSrc    = rd_is_pc;
        end
        S_BRANCH: begin
          RegSrc     = 2'b01;
          ImmSrc     = 2'b10;
          ALUSrc     = 1'b1;
          ALUControl = ALU_ADD;
          PCWrite    = 1'b1;
          PCSrc      = 1'b1;
          RegWrite   = Instr[24];
          linkSelect = Instr[24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller. Each instruction is expanded
// into its expected per-cycle control vectors, then replayed cycle by cycle.
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        mem_ack = 1'b0;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite;
  logic [1:0]  RegSrc, ImmSrc;
  logic        ALUSrc, MemtoReg, linkSelect;
  logic [3:0]  ALUControl;
  logic [2:0]  shiftOp;
  logic        registerShift, storedCarry, illegal_op;

  always #5 clk = ~clk;

  arm_mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ack(mem_ack),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .RegSrc(RegSrc),
    .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .linkSelect(linkSelect),
    .ALUControl(ALUControl), .shiftOp(shiftOp), .registerShift(registerShift),
    .storedCarry(storedCarry), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, pc_src, reg_write;
    logic [1:0] reg_src, imm_src;
    logic       alu_src, mem_to_reg, link_sel;
    logic [3:0] alu_ctl;
    logic [2:0] shift_op;
    logic       reg_shift, carry, illegal;
  } ctl_t;

  typedef struct {
    ctl_t exp;
    bit   ack;
    bit   upd;
    bit   fetch;
  } phase_t;

  ctl_t     got;
  phase_t   ph_q[$];
  logic [3:0] nzcv = 4'h0;
  int       n_checks = 0;
  int       n_fail = 0;

  assign got = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite,
                RegSrc, ImmSrc, ALUSrc, MemtoReg, linkSelect, ALUControl,
                shiftOp, registerShift, storedCarry, illegal_op};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit rnd_ack();
    return ($urandom_range(3) == 0);
  endfunction

  task automatic push(input ctl_t c, input bit ack, input bit upd, input bit fetch);
    phase_t p;
    p.exp = c; p.ack = ack; p.upd = upd; p.fetch = fetch;
    ph_q.push_back(p);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic build(input logic [31:0] ins, input int fw, input int mw);
    ctl_t c;
    bit   pass;
    logic [3:0] opc;
    ph_q.delete();
    for (int i = 0; i <= fw; i++) begin
      c = '0; c.mem_req = 1'b1;
      if (i == fw) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
      push(c, i == fw, 1'b0, 1'b1);
    end
    pass = cond_pass(ins[31:28], nzcv);
    c = '0; c.illegal = pass && (ins[27:26] == 2'b11);
    push(c, rnd_ack(), 1'b0, 1'b0);
    if (pass) begin
      case (ins[27:26])
        2'b00: begin
          opc = ins[24:21];
          c = '0; c.alu_ctl = opc; c.alu_src = ins[25];
          if (ins[25])                                                   c.shift_op = 3'b011;
          else if (ins[6:5] == 2'b11 && ins[11:7] == 5'd0 && !ins[4])   c.shift_op = 3'b100;
          else                                                           c.shift_op = {1'b0, ins[6:5]};
          if (!ins[25] && ins[4]) begin
            c.reg_shift = 1'b1;
            push(c, rnd_ack(), 1'b0, 1'b0);
          end
          push(c, rnd_ack(), ins[20] || (opc[3:2] == 2'b10), 1'b0);
          c = '0;
          c.reg_write = (opc[3:2] != 2'b10);
          c.pc_write  = c.reg_write && (ins[15:12] == 4'hF);
          c.pc_src    = c.pc_write;
          push(c, rnd_ack(), 1'b0, 1'b0);
        end
        2'b01: begin
          c = '0; c.imm_src = 2'b01; c.alu_src = 1'b1;
          c.alu_ctl = ins[23] ? 4'b0100 : 4'b0010;
          push(c, rnd_ack(), 1'b0, 1'b0);
          for (int i = 0; i <= mw; i++) begin
            c = '0; c.mem_req = 1'b1; c.adr_src = 1'b1;
            if (!ins[20]) begin c.mem_write = 1'b1; c.reg_src = 2'b10; end
            push(c, i == mw, 1'b0, 1'b0);
          end
          if (ins[20]) begin
            c = '0; c.mem_to_reg = 1'b1; c.reg_write = 1'b1;
            c.pc_write = (ins[15:12] == 4'hF); c.pc_src = c.pc_write;
            push(c, rnd_ack(), 1'b0, 1'b0);
          end
        end
        2'b10: begin
          c = '0; c.reg_src = 2'b01; c.imm_src = 2'b10; c.alu_src = 1'b1;
          c.alu_ctl = 4'b0100; c.pc_write = 1'b1; c.pc_src = 1'b1;
          c.reg_write = ins[24]; c.link_sel = ins[24];
          push(c, rnd_ack(), 1'b0, 1'b0);
        end
        default: ;
      endcase
    end
  endtask

  // Replay up to n expected cycles; fl < 0 drives random ALU flags each cycle.
  task automatic play(input logic [31:0] ins, input int n, input int fl);
    ctl_t e;
    logic [3:0] fd;
    for (int k = 0; k < ph_q.size() && k < n; k++) begin
      @(posedge clk); #1;
      mem_ack  = ph_q[k].ack;
      fd       = (fl < 0) ? 4'($urandom) : 4'(fl);
      ALUFlags = fd;
      Instr    = ph_q[k].fetch ? $urandom : ins;
      @(negedge clk);
      e = ph_q[k].exp;
      e.carry = nzcv[1];
      check_eq($sformatf("%h_c%0d", ins, k), {8'h0, got}, {8'h0, e});
      if (ph_q[k].upd) nzcv = fd;
    end
  endtask

  task automatic run(input logic [31:0] ins, input int fw, input int mw, input int fl);
    build(ins, fw, mw);
    play(ins, 1000, fl);
  endtask

  ctl_t fetch_only;

  initial begin
    fetch_only = '0;
    fetch_only.mem_req = 1'b1;

    // Held in reset: everything low
    repeat (3) @(negedge clk);
    check_eq("rst_hold", {8'h0, got}, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check_eq("rst_rel", {8'h0, got}, {8'h0, fetch_only});

    run(32'h0A000004, 2, 0, -1);  // BEQ, Z=0: not taken, fetch with 2 waits
    run(32'hE2921005, 0, 0, 6);   // ADDS R1,R2,#5 -> NZCV=0110
    check_eq("adds_carry", {31'h0, storedCarry}, 32'h1);
    run(32'h0A000004, 0, 0, -1);  // BEQ, Z=1: taken
    run(32'hE1B00061, 0, 0, -1);  // MOVS R0,R1,RRX
    run(32'hE0810312, 0, 0, -1);  // ADD R0,R1,R2,LSL R3
    run(32'hEB000010, 0, 0, -1);  // BL
    run(32'hE510F004, 0, 0, -1);  // LDR R15,[R0,#-4]
    run(32'hE5801000, 1, 2, -1);  // STR with waits
    run(32'hEC000000, 0, 0, -1);  // illegal op field 11
    run(32'hE3510000, 0, 0, 10);  // CMP R1,#0 -> NZCV=1010

    // Reset during a MEM_RD wait, with a stray ack in flight
    run(32'hE2921005, 0, 0, 6);
    build(32'hE5901004, 0, 3);
    play(32'hE5901004, 4, -1);
    @(posedge clk); #1;
    reset = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    check_eq("rst_mid", {8'h0, got}, 32'h0);
    check_eq("rst_mid_carry", {31'h0, storedCarry}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b0;
    nzcv = 4'h0;
    @(negedge clk);
    check_eq("rst_mid_rel", {8'h0, got}, {8'h0, fetch_only});
    run(32'h2A000000, 0, 0, -1);  // BCS with C=0 after reset: not taken

    for (int t = 0; t < 300; t++) begin
      run($urandom, $urandom_range(2), $urandom_range(2), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
